ring_counter_n: RTL and testbench
=================================

# ring_counter_n

Parametrised successor to the 4-bit one-hot ring counter. Generalised to WIDTH stages, with the following additions:
- runtime selection between one-hot ring and Johnson (twisted-ring) sequences;
- up/down direction and count enable;
- parallel load with legality checking;
- a step-index output and a wrap pulse.

It is used wherever the design needs a rotating phase/slot selector, or a glitch-free decoded sequencer of configurable length.

## Interface
- WIDTH, 4, number of stages; legal range 2..32.
- SW, $clog2(2*WIDTH), width of the step output (derived; do not override).
- clock  input  1  rising-edge clock; all state updates on this edge only.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  advance one step this cycle.
- dir  input  1  0 = up (toward higher bit index), 1 = down.
- mode  input  1  0 = one-hot ring (period WIDTH), 1 = Johnson (period 2*WIDTH).
- load  input  1  parallel load of load_value this cycle.
- load_value  input  WIDTH  value to load; checked for legality against the mode in effect.
- Q  output  WIDTH  registered counter state.
- step  output  SW  step index decoded combinationally from Q and the registered mode.
- wrap  output  1  registered one-cycle pulse marking a sequence boundary crossing.
- error  output  1  registered one-cycle pulse marking a corrected illegal state or rejected load.

## Operation
- Registered mode_q is captured from mode every cycle. A mode change is a cycle where mode != mode_q.
- Legal states:
  - Ring: exactly one bit set.
  - Johnson: one of the 2*WIDTH states reached from all-zero by up-shifts (0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000 for WIDTH=4).
- Shift rules:
  - Ring up: Q <= {Q[W-2:0], Q[W-1]}.
  - Ring down: Q <= {Q[0], Q[W-1:1]}.
  - Johnson up: Q <= {Q[W-2:0], ~Q[W-1]}.
  - Johnson down: Q <= {~Q[0], Q[W-1:1]}.
- step decode:
  - Ring: index of the set bit.
  - Johnson: 0 if Q is all-zero; popcount(Q) if Q[0]=1; otherwise 2*WIDTH - popcount(Q).
- The "new mode" below means the value of the mode input in that cycle. Priority per edge, highest first:
  1. reset.
  2. load: legal under the new mode → Q <= load_value. Illegal → Q <= 1 and error=1. No shift in either case.
  3. Illegal Q under the new mode (mode change, or corruption): Q <= 1, no shift. error=1 only if there was no mode change.
  4. enable: shift per dir under the new mode.
  5. Otherwise hold.
- wrap=1 only after an enabled shift that moved step from its maximum to 0 (up), or from 0 to its maximum (down). Maximum is WIDTH-1 for ring and 2*WIDTH-1 for Johnson. Loads and corrections never assert wrap.

## Timing
- Reset values: Q = 0...01, wrap = 0, error = 0, mode_q = mode.
- Resulting step after reset: 0 in ring mode, 1 in Johnson mode.
- reset held with load/enable active: reset wins, with the same values as above.
- Latency:
  - Q, wrap and error change one cycle after the sampling edge.
  - step follows Q combinationally, with no added latency.
- wrap and error are single-cycle pulses. They deassert on the next edge unless that edge re-qualifies.
- Simultaneous load and enable: load wins; the loaded value appears unshifted.
- Mode change with enable and Q legal under the new mode: the shift uses the new mode in the same cycle.
- Enable held continuously: one step per cycle, no bubbles. Direction may change on any cycle.

## Test plan
- WIDTH=4, ring up: reset, then enable 4 cycles → Q 0010, 0100, 1000, 0001; step 1, 2, 3, 0; wrap=1 only with the final 0001.
- Johnson up: mode=1, reset, enable 8 cycles → Q 0011, 0111, 1111, 1110, 1100, 1000, 0000, 0001; wrap=1 only when Q=0000; step 2..7, 0, 1.
- Ring down from reset:
  - 1 enable → Q=1000, step=3, wrap=1.
  - Then dir=0 with 1 enable → Q=0001, wrap=1.
- Ring load:
  - load_value=0110 → Q=0001, error=1 for one cycle.
  - load_value=0100 with enable=1 → Q=0100, error=0, no shift.
- Mode change:
  - Ring Q=0100, switch to Johnson → Q=0001, error=0.
  - Johnson Q=1000, switch to ring → Q stays 1000, then enable up → Q=0001 with wrap=1.
- Reset mid-count: Johnson at Q=1110, assert reset with enable=1 and load=1 → next edge Q=0001, wrap=0, error=0.

Source files
------------

// File: rtl/ring_counter_n_if.sv
// ring_counter_n_if: control/status bundle for ring_counter_n.
//   master : drives enable, dir, mode, load, load_value; observes Q, step, wrap, error
//   slave  : the counter side (inverse directions)
// step is $clog2(2*WIDTH) bits wide so it can hold every Johnson step index.
interface ring_counter_n_if #(
  parameter int unsigned WIDTH = 4
);
  localparam int unsigned SW = $clog2(2 * WIDTH);

  logic             enable;
  logic             dir;
  logic             mode;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] Q;
  logic [SW-1:0]    step;
  logic             wrap;
  logic             error;

  modport master (
    output enable, dir, mode, load, load_value,
    input  Q, step, wrap, error
  );

  modport slave (
    input  enable, dir, mode, load, load_value,
    output Q, step, wrap, error
  );
endinterface

// File: rtl/ring_counter_n.sv
// ring_counter_n: WIDTH-stage rotating phase selector, one-hot ring or Johnson
// sequence selected at runtime, with up/down shifting, count enable, checked
// parallel load, combinational step index and registered wrap/error pulses.
//   clock : rising-edge clock
//   reset : synchronous active-high reset (Q -> 0..01)
//   bus   : ring_counter_n_if.slave (enable, dir, mode, load, load_value in;
//           Q, step, wrap, error out)
module ring_counter_n #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  ring_counter_n_if.slave  bus
);
  localparam int unsigned SW = $clog2(2 * WIDTH);

  typedef logic [WIDTH-1:0] vec_t;
  typedef logic [SW-1:0]    step_t;

  localparam vec_t ONE = vec_t'(1);

  vec_t  q;
  logic  mode_q;
  logic  wrap_q;
  logic  error_q;
  vec_t  shift_q;
  logic  wrap_hit;
  logic  load_ok;
  logic  q_ok;

  // Ring: exactly one bit set. Johnson: a run of ones anchored at bit 0
  // (thermometer) or its complement, including all-zero and all-one.
  function automatic logic is_legal(input vec_t v, input logic m);
    logic ok;
    vec_t lo;
    ok = 1'b0;
    if (!m) begin
      ok = $onehot(v);
    end else begin
      for (int unsigned k = 0; k <= WIDTH; k++) begin
        lo = '0;
        for (int unsigned j = 0; j < WIDTH; j++) lo[j] = (j < k);
        if (v == lo || v == ~lo) ok = 1'b1;
      end
    end
    return ok;
  endfunction

  function automatic step_t step_of(input vec_t v, input logic m);
    step_t s;
    int    pop;
    s = '0;
    if (!m) begin
      // downward scan leaves the lowest set bit's index
      for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
        if (v[i]) s = step_t'(i);
      end
    end else begin
      pop = $countones(v);
      if (v == '0)  s = '0;
      else if (v[0]) s = step_t'(pop);
      else           s = step_t'(int'(2 * WIDTH) - pop);
    end
    return s;
  endfunction

  function automatic step_t max_step(input logic m);
    return m ? step_t'(2 * WIDTH - 1) : step_t'(WIDTH - 1);
  endfunction

  // Shift and wrap detection both use the incoming mode so a mode change
  // with enable takes effect on the same edge.
  always_comb begin
    shift_q  = q;
    wrap_hit = 1'b0;
    if (bus.mode) begin
      shift_q = bus.dir ? {~q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], ~q[WIDTH-1]};
    end else begin
      shift_q = bus.dir ? {q[0], q[WIDTH-1:1]} : {q[WIDTH-2:0], q[WIDTH-1]};
    end
    if (bus.dir) begin
      wrap_hit = (step_of(q, bus.mode) == '0) &&
                 (step_of(shift_q, bus.mode) == max_step(bus.mode));
    end else begin
      wrap_hit = (step_of(q, bus.mode) == max_step(bus.mode)) &&
                 (step_of(shift_q, bus.mode) == '0);
    end
    load_ok = is_legal(bus.load_value, bus.mode);
    q_ok    = is_legal(q, bus.mode);
  end

  always_ff @(posedge clock) begin
    mode_q <= bus.mode;
    if (reset) begin
      q       <= ONE;
      wrap_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      wrap_q  <= 1'b0;
      error_q <= 1'b0;
      if (bus.load) begin
        if (load_ok) begin
          q <= bus.load_value;
        end else begin
          q       <= ONE;
          error_q <= 1'b1;
        end
      end else if (!q_ok) begin
        // state made illegal by a mode switch is recovered silently;
        // otherwise it indicates corruption and is flagged
        q       <= ONE;
        error_q <= (bus.mode == mode_q);
      end else if (bus.enable) begin
        q      <= shift_q;
        wrap_q <= wrap_hit;
      end
    end
  end

  assign bus.Q     = q;
  assign bus.step  = step_of(q, mode_q);
  assign bus.wrap  = wrap_q;
  assign bus.error = error_q;
endmodule

// File: tb/tb_ring_counter_n.sv
// tb_ring_counter_n: directed scoreboard bench for ring_counter_n at WIDTH=4.
module tb_ring_counter_n;
  logic clock;
  logic reset;
  int   checks;
  int   errors;

  ring_counter_n_if #(.WIDTH(4)) bus ();

  ring_counter_n #(.WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    string      tag;
    logic [3:0] q;
    logic [2:0] st;
    logic       w;
    logic       e;
  } exp_t;

  exp_t sb[$];

  // Drive one cycle of inputs, record the expected post-edge outputs,
  // then sample #1 after the edge and compare against the scoreboard.
  task automatic cyc(input string tag, input logic r, input logic en,
                     input logic d, input logic m, input logic ld,
                     input logic [3:0] lv, input logic [3:0] eq,
                     input logic [2:0] es, input logic ew, input logic ee);
    exp_t x;
    reset          = r;
    bus.enable     = en;
    bus.dir        = d;
    bus.mode       = m;
    bus.load       = ld;
    bus.load_value = lv;
    sb.push_back('{tag, eq, es, ew, ee});
    @(posedge clock);
    #1;
    x = sb.pop_front();
    checks++;
    assert (bus.Q === x.q) else begin
      errors++;
      $error("FAIL %s Q got %b expected %b", x.tag, bus.Q, x.q);
    end
    checks++;
    assert (bus.step === x.st) else begin
      errors++;
      $error("FAIL %s step got %0d expected %0d", x.tag, bus.step, x.st);
    end
    checks++;
    assert (bus.wrap === x.w) else begin
      errors++;
      $error("FAIL %s wrap got %b expected %b", x.tag, bus.wrap, x.w);
    end
    checks++;
    assert (bus.error === x.e) else begin
      errors++;
      $error("FAIL %s error got %b expected %b", x.tag, bus.error, x.e);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.enable = 1'b0;
    bus.dir = 1'b0;
    bus.mode = 1'b0;
    bus.load = 1'b0;
    bus.load_value = '0;

    //   tag            r  en d  m  ld lv       Q        st w  e
    cyc("rst_ring",     1, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
    cyc("ring_up1",     0, 1, 0, 0, 0, 4'b0000, 4'b0010, 1, 0, 0);
    cyc("ring_up2",     0, 1, 0, 0, 0, 4'b0000, 4'b0100, 2, 0, 0);
    cyc("ring_up3",     0, 1, 0, 0, 0, 4'b0000, 4'b1000, 3, 0, 0);
    cyc("ring_up4",     0, 1, 0, 0, 0, 4'b0000, 4'b0001, 0, 1, 0);
    cyc("ring_hold",    0, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);

    cyc("rst_john",     1, 0, 0, 1, 0, 4'b0000, 4'b0001, 1, 0, 0);
    cyc("john_up1",     0, 1, 0, 1, 0, 4'b0000, 4'b0011, 2, 0, 0);
    cyc("john_up2",     0, 1, 0, 1, 0, 4'b0000, 4'b0111, 3, 0, 0);
    cyc("john_up3",     0, 1, 0, 1, 0, 4'b0000, 4'b1111, 4, 0, 0);
    cyc("john_up4",     0, 1, 0, 1, 0, 4'b0000, 4'b1110, 5, 0, 0);
    cyc("john_up5",     0, 1, 0, 1, 0, 4'b0000, 4'b1100, 6, 0, 0);
    cyc("john_up6",     0, 1, 0, 1, 0, 4'b0000, 4'b1000, 7, 0, 0);
    cyc("john_up7",     0, 1, 0, 1, 0, 4'b0000, 4'b0000, 0, 1, 0);
    cyc("john_up8",     0, 1, 0, 1, 0, 4'b0000, 4'b0001, 1, 0, 0);
    cyc("john_dn1",     0, 1, 1, 1, 0, 4'b0000, 4'b0000, 0, 0, 0);
    cyc("john_dn2",     0, 1, 1, 1, 0, 4'b0000, 4'b1000, 7, 1, 0);

    cyc("rst_ring2",    1, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
    cyc("ring_dn",      0, 1, 1, 0, 0, 4'b0000, 4'b1000, 3, 1, 0);
    cyc("ring_dn_up",   0, 1, 0, 0, 0, 4'b0000, 4'b0001, 0, 1, 0);

    cyc("ld_illegal",   0, 0, 0, 0, 1, 4'b0110, 4'b0001, 0, 0, 1);
    cyc("err_clear",    0, 0, 0, 0, 0, 4'b0000, 4'b0001, 0, 0, 0);
    cyc("ld_with_en",   0, 1, 0, 0, 1, 4'b0100, 4'b0100, 2, 0, 0);

    cyc("mc_to_john",   0, 0, 0, 1, 0, 4'b0000, 4'b0001, 1, 0, 0);
    cyc("john_ld1000",  0, 0, 0, 1, 1, 4'b1000, 4'b1000, 7, 0, 0);
    cyc("mc_to_ring",   0, 0, 0, 0, 0, 4'b0000, 4'b1000, 3, 0, 0);
    cyc("mc_ring_up",   0, 1, 0, 0, 0, 4'b0000, 4'b0001, 0, 1, 0);
    cyc("mc_en_john",   0, 1, 0, 1, 0, 4'b0000, 4'b0011, 2, 0, 0);
    cyc("john_ld_bad",  0, 0, 0, 1, 1, 4'b0101, 4'b0001, 1, 0, 1);

    cyc("john_ld1110",  0, 0, 0, 1, 1, 4'b1110, 4'b1110, 5, 0, 0);
    cyc("rst_midcount", 1, 1, 0, 1, 1, 4'b0110, 4'b0001, 1, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
